spi_frame_ctrl: RTL
===================

SPI_FRAME_CTRL -- requirements
Module: spi_frame_ctrl

Interface
REQ-001 Parameter ADDR_W, default 3: register address width.
REQ-002 Parameter REG_W, default 8: register data width; one data frame carries REG_W bits.
REQ-003 clk  input  1  system clock; the block's only clock.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 ena  input  1  block enable; when low, the block SHALL hold IDLE and ignore SPI activity.
REQ-006 spi_cs_n  input  1  SPI chip select, active-low, asynchronous to clk.
REQ-007 spi_clk  input  1  SPI clock, mode 0, asynchronous to clk.
REQ-008 spi_mosi  input  1  SPI serial data in, MSB first.
REQ-009 spi_miso  output  1  SPI serial data out, MSB first; driven 0 when idle, never tri-stated.
REQ-010 reg_addr  output  ADDR_W  address decoded from the command byte; holds its value after the frame.
REQ-011 reg_data_i  input  REG_W  read data for reg_addr, supplied combinationally by the register bank.
REQ-012 reg_data_o  output  REG_W  write data.
REQ-013 reg_data_o_dv  output  1  single-cycle write strobe.
REQ-014 status  input  8  status byte returned during the command byte.

Function
REQ-015 spi_cs_n, spi_clk and spi_mosi SHALL each pass through a 2-flop synchronizer; edges SHALL be detected on the synchronized signals. The requirement is f_clk >= 4 x f_spi_clk.
REQ-016 The FSM SHALL have four states: IDLE, CMD, DATA and DONE.
REQ-017 IDLE -> CMD occurs on the synchronized spi_cs_n falling edge while ena=1; the bit counter clears.
REQ-018 CMD: mosi is sampled on each synchronized spi_clk rising edge, 8 bits total. Command byte layout: bit7=1 means write, 0 means read; bits[ADDR_W-1:0] are the address; the remaining bits are ignored.
REQ-019 CMD -> DATA after the 8th rising edge; reg_addr is updated in the same cycle.
REQ-020 DATA: REG_W bits are sampled on rising edges. After the REG_W-th edge the FSM moves to DONE.
REQ-021 On a write, reg_data_o is updated and reg_data_o_dv is asserted for exactly one clk cycle, in the cycle after the last data bit is sampled.
REQ-022 DONE: all further spi_clk edges are ignored; no second strobe is generated; the FSM returns to IDLE on the spi_cs_n rising edge.
REQ-023 MISO, CMD phase: status is loaded into the tx shifter on entry to CMD and its MSB is driven immediately; the shifter advances on each synchronized spi_clk falling edge.
REQ-024 MISO, read: on CMD -> DATA, reg_data_i (for the new reg_addr) is loaded into the tx shifter and its MSB is driven before the first DATA rising edge.
REQ-025 MISO, write: the block drives 0 during DATA.
REQ-026 Abort: spi_cs_n rising in any state returns the FSM to IDLE next cycle with no strobe, and spi_miso returns to 0.
REQ-027 If spi_cs_n rising and the final rising spi_clk edge are detected in the same cycle, the spi_cs_n rising edge wins and no write occurs.
REQ-028 If ena is deasserted mid-frame, the FSM returns to IDLE with no strobe.
REQ-029 Bit counter width is $clog2(max(8,REG_W))+1; it never wraps within a frame.

Reset
REQ-030 On rst=1 all outputs and state clear asynchronously: FSM=IDLE, reg_addr=0, reg_data_o=0, reg_data_o_dv=0, spi_miso=0; synchronizer flops reset spi_cs_n to 1 and spi_clk and spi_mosi to 0.
REQ-031 Reset asserted mid-frame aborts the frame with no strobe. After release, the block waits for a fresh spi_cs_n falling edge.

Structure
REQ-032 A shared package spi_pkg SHALL hold the FSM state enum, the CMD_BITS=8 constant and the write-bit index (7).
REQ-033 The 2-flop synchronizer SHALL be a sub-module, sync_2ff, instantiated three times.
REQ-034 The design SHALL contain no latches, no logic clocked by spi_clk, and no combinational path from SPI inputs to spi_miso.

Verification
REQ-035 Write frame, cmd 0x83 then data 0xA5 -> reg_addr=3, reg_data_o=0xA5, reg_data_o_dv high for exactly 1 cycle.
REQ-036 Read frame, cmd 0x05 with reg_data_i=0x3C and status=0x81 -> MISO returns 0x81 during CMD and 0x3C during DATA; no strobe.
REQ-037 spi_cs_n raised after 4 data bits of a write frame -> no strobe; a following full frame works normally.
REQ-038 Twelve extra spi_clk pulses after the data byte before spi_cs_n rises -> exactly one strobe.
REQ-039 rst pulsed mid-CMD, then ena=0 during a complete frame -> all outputs 0, no strobe; a following enabled frame succeeds.
REQ-040 Back-to-back frames to addresses 0..7, with spi_cs_n high for 2 spi_clk periods between frames -> 8 strobes with matching addresses and data.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register-access frame controller.
package spi_pkg;

    // Frame controller FSM states.
    typedef enum logic [1:0] {
        StIdle,
        StCmd,
        StData,
        StDone
    } spi_state_e;

    // Length of the command byte and position of its write flag.
    localparam int unsigned CMD_BITS = 8;
    localparam int unsigned WR_BIT   = 7;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] ff_q;

    // Shift the raw input through two flops; reset to the line's idle level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff_q <= {2{RST_VAL}};
        end else begin
            ff_q <= {ff_q[0], d_i};
        end
    end

    assign q_o = ff_q[1];

endmodule

// File: rtl/spi_frame_ctrl.sv
// SPI mode-0 slave that decodes a command byte and one data frame into
// register-bank reads and single-cycle write strobes. All logic runs on clk.
module spi_frame_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned REG_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              spi_cs_n,
    input  logic              spi_clk,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic [ADDR_W-1:0] reg_addr,
    input  logic [REG_W-1:0]  reg_data_i,
    output logic [REG_W-1:0]  reg_data_o,
    output logic              reg_data_o_dv,
    input  logic [7:0]        status
);

    localparam int unsigned SH_W  = max_u(CMD_BITS, REG_W);
    localparam int unsigned CNT_W = $clog2(SH_W) + 1;

    logic cs_s, sclk_s, mosi_s;
    logic cs_prev_q, sclk_prev_q;
    logic [1:0] arm_q, arm_d;
    logic cs_fall, cs_rise, sclk_rise, sclk_fall;

    spi_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SH_W-2:0]   rx_q, rx_d;
    logic [SH_W-1:0]   rx_next;
    logic [SH_W-1:0]   tx_q, tx_d;
    logic              wr_q, wr_d;
    logic              load_q, load_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [REG_W-1:0]  data_q, data_d;
    logic              dv_q, dv_d;

    sync_2ff #(.RST_VAL(1'b1)) u_sync_cs (
        .clk (clk),
        .rst (rst),
        .d_i (spi_cs_n),
        .q_o (cs_s)
    );

    sync_2ff #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk (clk),
        .rst (rst),
        .d_i (spi_clk),
        .q_o (sclk_s)
    );

    sync_2ff #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk (clk),
        .rst (rst),
        .d_i (spi_mosi),
        .q_o (mosi_s)
    );

    // Previous synchronized levels for edge detection, plus the chip-select arm counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_prev_q   <= 1'b1;
            sclk_prev_q <= 1'b0;
            arm_q       <= '0;
        end else begin
            cs_prev_q   <= cs_s;
            sclk_prev_q <= sclk_s;
            arm_q       <= arm_d;
        end
    end

    // A frame may only start once chip select has been seen high for three cycles, so a
    // reset released while chip select is already low cannot fake a falling edge.
    always_comb begin
        arm_d = arm_q;
        if (!cs_s) begin
            arm_d = '0;
        end else if (arm_q != 2'd3) begin
            arm_d = arm_q + 2'd1;
        end
    end

    assign cs_fall   = cs_prev_q & ~cs_s & (arm_q == 2'd3);
    assign cs_rise   = ~cs_prev_q & cs_s;
    assign sclk_rise = ~sclk_prev_q & sclk_s;
    assign sclk_fall = sclk_prev_q & ~sclk_s;
    assign rx_next   = {rx_q, mosi_s};

    // Frame state and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rx_q    <= '0;
            tx_q    <= '0;
            wr_q    <= 1'b0;
            load_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            dv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rx_q    <= rx_d;
            tx_q    <= tx_d;
            wr_q    <= wr_d;
            load_q  <= load_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            dv_q    <= dv_d;
        end
    end

    // Next-state and datapath update; chip-select release or disable aborts any frame.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rx_d    = rx_q;
        tx_d    = tx_q;
        wr_d    = wr_q;
        load_d  = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        dv_d    = 1'b0;

        if (!ena || cs_rise) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cs_fall) begin
                        state_d                = StCmd;
                        cnt_d                  = '0;
                        tx_d                   = '0;
                        tx_d[SH_W-1 -: 8]      = status;
                    end
                end
                StCmd: begin
                    // The bit already on MISO is held until the master has sampled it.
                    if (sclk_fall && (cnt_q != '0)) begin
                        tx_d = tx_q << 1;
                    end
                    if (sclk_rise) begin
                        rx_d  = rx_next[SH_W-2:0];
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(CMD_BITS - 1)) begin
                            state_d = StData;
                            cnt_d   = '0;
                            wr_d    = rx_next[WR_BIT];
                            addr_d  = rx_next[ADDR_W-1:0];
                            // Read data is valid one cycle after reg_addr moves.
                            load_d  = ~rx_next[WR_BIT];
                            tx_d    = '0;
                        end
                    end
                end
                StData: begin
                    if (load_q) begin
                        tx_d                   = '0;
                        tx_d[SH_W-1 -: REG_W]  = reg_data_i;
                    end else if (sclk_fall && (cnt_q != '0)) begin
                        tx_d = tx_q << 1;
                    end
                    if (sclk_rise) begin
                        rx_d  = rx_next[SH_W-2:0];
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(REG_W - 1)) begin
                            state_d = StDone;
                            if (wr_q) begin
                                data_d = rx_next[REG_W-1:0];
                                dv_d   = 1'b1;
                            end
                        end
                    end
                end
                StDone: begin
                    state_d = StDone;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    assign spi_miso      = ((state_q == StCmd) || (state_q == StData)) ? tx_q[SH_W-1] : 1'b0;
    assign reg_addr      = addr_q;
    assign reg_data_o    = data_q;
    assign reg_data_o_dv = dv_q;

endmodule
